// File: rtl/ball_object.sv
// Bouncing square sprite: per-frame motion with wall reflection,
// plus a registered per-pixel in-ball test and colour lanes.
module ball_object #(
  parameter int         H_MAX = 640,
  parameter int         V_MAX = 480,
  parameter int         SIZE  = 8,
  parameter int         VEL   = 2,
  parameter logic [2:0] COLOR = 3'b010
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refr_tick,
  input  logic       video_on,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       start,
  input  logic       pause,
  output logic       obj_on,
  output logic       obj_r,
  output logic       obj_g,
  output logic       obj_b,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       bounce,
  output logic [7:0] hit_count
);

  localparam logic [9:0] X_HI  = 10'(H_MAX - SIZE - VEL);
  localparam logic [9:0] X_END = 10'(H_MAX - SIZE);
  localparam logic [9:0] Y_HI  = 10'(V_MAX - SIZE - VEL);
  localparam logic [9:0] Y_END = 10'(V_MAX - SIZE);
  localparam logic [9:0] X_RST = 10'((H_MAX - SIZE) / 2);
  localparam logic [9:0] Y_RST = 10'((V_MAX - SIZE) / 2);
  localparam logic [9:0] V10   = 10'(VEL);
  localparam logic [10:0] SZM1 = 11'(SIZE - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED
  } state_t;

  state_t     state_q, state_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       dx_q, dx_d;
  logic       dy_q, dy_d;
  logic       bounce_q, bounce_d;
  logic [7:0] hit_q, hit_d;
  logic       on_q, on_d;
  logic [2:0] rgb_q, rgb_d;
  logic       move;
  logic       hx, hy;
  logic       in_x, in_y;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      x_q      <= X_RST;
      y_q      <= Y_RST;
      dx_q     <= 1'b1;
      dy_q     <= 1'b1;
      bounce_q <= 1'b0;
      hit_q    <= '0;
      on_q     <= 1'b0;
      rgb_q    <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      bounce_q <= bounce_d;
      hit_q    <= hit_d;
      on_q     <= on_d;
      rgb_q    <= rgb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start)  state_d = RUN;
      RUN:     if (pause)  state_d = PAUSED;
      PAUSED:  if (!pause) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Motion uses the pre-transition state, so a tick alongside
  // start does nothing and a tick alongside pause still moves.
  assign move = refr_tick && (state_q == RUN);

  always_comb begin
    x_d  = x_q;
    dx_d = dx_q;
    hx   = 1'b0;
    if (move) begin
      if (dx_q) begin
        if (x_q >= X_HI) begin
          x_d  = X_END;
          dx_d = 1'b0;
          hx   = 1'b1;
        end else begin
          x_d = x_q + V10;
        end
      end else begin
        if (x_q <= V10) begin
          x_d  = '0;
          dx_d = 1'b1;
          hx   = 1'b1;
        end else begin
          x_d = x_q - V10;
        end
      end
    end
  end

  always_comb begin
    y_d  = y_q;
    dy_d = dy_q;
    hy   = 1'b0;
    if (move) begin
      if (dy_q) begin
        if (y_q >= Y_HI) begin
          y_d  = Y_END;
          dy_d = 1'b0;
          hy   = 1'b1;
        end else begin
          y_d = y_q + V10;
        end
      end else begin
        if (y_q <= V10) begin
          y_d  = '0;
          dy_d = 1'b1;
          hy   = 1'b1;
        end else begin
          y_d = y_q - V10;
        end
      end
    end
  end

  // A corner hit counts once.
  assign bounce_d = hx || hy;
  assign hit_d    = hit_q + {7'd0, bounce_d};

  assign in_x = ({1'b0, pixel_x} >= {1'b0, x_q}) &&
                ({1'b0, pixel_x} <= {1'b0, x_q} + SZM1);
  assign in_y = ({1'b0, pixel_y} >= {1'b0, y_q}) &&
                ({1'b0, pixel_y} <= {1'b0, y_q} + SZM1);
  assign on_d  = video_on && in_x && in_y;
  assign rgb_d = COLOR & {3{on_d}};

  assign obj_on    = on_q;
  assign obj_r     = rgb_q[0];
  assign obj_g     = rgb_q[1];
  assign obj_b     = rgb_q[2];
  assign ball_x    = x_q;
  assign ball_y    = y_q;
  assign bounce    = bounce_q;
  assign hit_count = hit_q;

endmodule

// File: tb/tb_ball_object.sv
// Scoreboard bench for ball_object: default instance for motion,
// pixel test and pause; a small instance for corner and wrap cases.
module tb_ball_object;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       refr_tick = 1'b0;
  logic       video_on = 1'b0;
  logic [9:0] pixel_x = '0;
  logic [9:0] pixel_y = '0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       obj_on, obj_r, obj_g, obj_b;
  logic [9:0] ball_x, ball_y;
  logic       bounce;
  logic [7:0] hit_count;

  logic       s_tick = 1'b0;
  logic       s_start = 1'b0;
  logic       s_on, s_r, s_g, s_b;
  logic [9:0] s_x, s_y;
  logic       s_bounce;
  logic [7:0] s_hit;

  always #5 clk = ~clk;

  ball_object dut (
    .clk(clk), .reset(reset), .refr_tick(refr_tick),
    .video_on(video_on), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .start(start), .pause(pause),
    .obj_on(obj_on), .obj_r(obj_r), .obj_g(obj_g), .obj_b(obj_b),
    .ball_x(ball_x), .ball_y(ball_y), .bounce(bounce),
    .hit_count(hit_count)
  );

  ball_object #(.H_MAX(24), .V_MAX(24)) sdut (
    .clk(clk), .reset(reset), .refr_tick(s_tick),
    .video_on(1'b0), .pixel_x(10'd0), .pixel_y(10'd0),
    .start(s_start), .pause(1'b0),
    .obj_on(s_on), .obj_r(s_r), .obj_g(s_g), .obj_b(s_b),
    .ball_x(s_x), .ball_y(s_y), .bounce(s_bounce),
    .hit_count(s_hit)
  );

  typedef struct {
    int x;
    int y;
    bit b;
    int h;
  } exp_t;

  exp_t sbq[$];
  bit   pq[$];
  int   errors = 0;
  int   checks = 0;

  int   mx, my, mhit, mst;
  bit   mdx, mdy;

  task automatic model_reset();
    mx = 316; my = 236; mdx = 1; mdy = 1; mhit = 0; mst = 0;
  endtask

  task automatic model_fsm(input bit s, input bit p);
    case (mst)
      0: if (s) mst = 1;
      1: if (p) mst = 2;
      default: if (!p) mst = 1;
    endcase
  endtask

  task automatic model_axis(inout int p, inout bit d,
                            input int lim, output bit h);
    h = 0;
    if (d) begin
      if (p >= lim - 8 - 2) begin p = lim - 8; d = 0; h = 1; end
      else p = p + 2;
    end else begin
      if (p <= 2) begin p = 0; d = 1; h = 1; end
      else p = p - 2;
    end
  endtask

  task automatic frame(input bit s, input bit p);
    exp_t e;
    bit hx, hy;
    @(negedge clk);
    refr_tick = 1; start = s; pause = p;
    hx = 0; hy = 0;
    if (mst == 1) begin
      model_axis(mx, mdx, 640, hx);
      model_axis(my, mdy, 480, hy);
      if (hx || hy) mhit = (mhit + 1) % 256;
    end
    e.x = mx; e.y = my; e.b = hx | hy; e.h = mhit;
    sbq.push_back(e);
    model_fsm(s, p);
    @(posedge clk); #1;
    e = sbq.pop_front();
    checks++;
    if (ball_x !== 10'(e.x) || ball_y !== 10'(e.y)) begin
      errors++;
      $display("FAIL pos: got %0d/%0d want %0d/%0d",
               ball_x, ball_y, e.x, e.y);
    end
    checks++;
    if (bounce !== e.b) begin
      errors++;
      $display("FAIL bounce: got %b want %b", bounce, e.b);
    end
    checks++;
    if (hit_count !== 8'(e.h)) begin
      errors++;
      $display("FAIL hit_count: got %0d want %0d", hit_count, e.h);
    end
    @(negedge clk);
    refr_tick = 0; start = 0;
    model_fsm(0, p);
    @(posedge clk); #1;
    checks++;
    if (bounce !== 1'b0) begin
      errors++;
      $display("FAIL bounce_len: got %b want 0", bounce);
    end
  endtask

  task automatic scan(input int x, input int y, input bit v);
    bit eo, got;
    @(negedge clk);
    pixel_x = 10'(x); pixel_y = 10'(y); video_on = v;
    eo = v && x >= mx && x <= mx + 7 && y >= my && y <= my + 7;
    pq.push_back(eo);
    model_fsm(0, pause);
    @(posedge clk); #1;
    got = pq.pop_front();
    checks++;
    if ({obj_on, obj_b, obj_g, obj_r} !== {got, 1'b0, got, 1'b0}) begin
      errors++;
      $display("FAIL pixel(%0d,%0d,%b): got on=%b bgr=%b%b%b want on=%b",
               x, y, v, obj_on, obj_b, obj_g, obj_r, got);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    reset = 0;
    model_reset();
    @(posedge clk); #1;
    checks++;
    if (ball_x !== 10'd316 || ball_y !== 10'd236 || hit_count !== 8'd0 ||
        bounce !== 1'b0 || obj_on !== 1'b0 ||
        {obj_r, obj_g, obj_b} !== 3'b000) begin
      errors++;
      $display("FAIL reset: got x=%0d y=%0d h=%0d b=%b on=%b want 316/236/0/0/0",
               ball_x, ball_y, hit_count, bounce, obj_on);
    end
  endtask

  task automatic test_pixel();
    scan(316, 236, 1);
    scan(323, 243, 1);
    scan(324, 236, 1);
    scan(316, 244, 1);
    scan(315, 240, 1);
    scan(318, 238, 0);
  endtask

  task automatic test_idle_start();
    repeat (3) frame(0, 0);
    frame(1, 0);
    frame(0, 0);
    checks++;
    if (ball_x !== 10'd318 || ball_y !== 10'd238) begin
      errors++;
      $display("FAIL first_move: got %0d/%0d want 318/238", ball_x, ball_y);
    end
  endtask

  task automatic test_right_wall();
    int n = 0;
    while (mx != 630 && n < 400) begin
      frame(0, 0);
      n++;
    end
    checks++;
    if (mx != 630) begin
      errors++;
      $display("FAIL wall_budget: got %0d frames want reach 630", n);
    end
    frame(0, 0);
    frame(0, 0);
    checks++;
    if (ball_x !== 10'd630) begin
      errors++;
      $display("FAIL wall_return: got %0d want 630", ball_x);
    end
  endtask

  task automatic test_pause();
    int px, py;
    frame(0, 1);
    px = mx; py = my;
    repeat (5) frame(0, 1);
    checks++;
    if (ball_x !== 10'(px) || ball_y !== 10'(py)) begin
      errors++;
      $display("FAIL paused_pos: got %0d/%0d want %0d/%0d",
               ball_x, ball_y, px, py);
    end
    scan(px + 3, py + 3, 1);
    @(negedge clk);
    pause = 0;
    model_fsm(0, 0);
    frame(0, 0);
    checks++;
    if (ball_x === 10'(px) || ball_y === 10'(py)) begin
      errors++;
      $display("FAIL resume: got %0d/%0d want moved from %0d/%0d",
               ball_x, ball_y, px, py);
    end
  endtask

  task automatic test_reset_mid_run();
    int n = 0;
    while (mhit != 5 && n < 1500) begin
      frame(0, 0);
      n++;
    end
    checks++;
    if (mhit != 5 || hit_count !== 8'd5) begin
      errors++;
      $display("FAIL hit5: got %0d want 5", hit_count);
    end
    scan(mx, my, 1);
    @(negedge clk);
    #2 reset = 1;
    #1;
    checks++;
    if (ball_x !== 10'd316 || ball_y !== 10'd236 || hit_count !== 8'd0 ||
        {obj_on, obj_r, obj_g, obj_b} !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset: got x=%0d y=%0d h=%0d on=%b want 316/236/0/0",
               ball_x, ball_y, hit_count, obj_on);
    end
    @(negedge clk);
    reset = 0;
    video_on = 0;
    model_reset();
    frame(0, 0);
  endtask

  task automatic test_corner_wrap();
    int n = 0;
    int seen = 0;
    @(negedge clk); s_start = 1;
    @(negedge clk); s_start = 0;
    repeat (4) begin
      @(negedge clk); s_tick = 1;
      @(posedge clk); #1;
      if (s_bounce) seen++;
      @(negedge clk); s_tick = 0;
      n++;
    end
    checks++;
    if (s_x !== 10'd16 || s_y !== 10'd16 || seen != 1 || s_hit !== 8'd1) begin
      errors++;
      $display("FAIL corner: got %0d/%0d pulses=%0d h=%0d want 16/16/1/1",
               s_x, s_y, seen, s_hit);
    end
    @(posedge clk); #1;
    checks++;
    if (s_bounce !== 1'b0) begin
      errors++;
      $display("FAIL corner_pulse: got %b want 0", s_bounce);
    end
    while (seen < 256 && n < 3000) begin
      @(negedge clk); s_tick = 1;
      @(posedge clk); #1;
      if (s_bounce) seen++;
      @(negedge clk); s_tick = 0;
      n++;
      if (seen == 255 && s_bounce) begin
        checks++;
        if (s_hit !== 8'd255) begin
          errors++;
          $display("FAIL hit255: got %0d want 255", s_hit);
        end
      end
    end
    checks++;
    if (seen != 256 || s_hit !== 8'd0) begin
      errors++;
      $display("FAIL wrap: got h=%0d pulses=%0d want 0/256", s_hit, seen);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_pixel();
    test_idle_start();
    test_right_wall();
    test_pause();
    test_reset_mid_run();
    test_corner_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
